// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the mem_lsu_sb load/store unit.
// Optional store-to-load forwarding is enabled with the LSU_SB_FORWARD_EN macro.
package lsu_pkg;

  // Buffer entries carry a fixed-width address; modules use the low ADDR_W bits.
  localparam int SB_ADDR_MAX = 64;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_ADDR = 3'd1,
    LD_DATA = 3'd2,
    ST_ADDR = 3'd3,
    ST_DATA = 3'd4
  } lsu_state_e;

  typedef struct packed {
    logic [SB_ADDR_MAX-1:0] addr;
    logic [3:0]             wstrb;
    logic [31:0]            wdata;
    lsu_size_e              size;
  } sb_entry_t;

  function automatic lsu_size_e norm_size(input logic [1:0] s);
    lsu_size_e r;
    case (s)
      2'd0:    r = SZ_BYTE;
      2'd1:    r = SZ_HALF;
      default: r = SZ_WORD;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input lsu_size_e size, input logic [1:0] a);
    logic r;
    case (size)
      SZ_HALF: r = a[0];
      SZ_WORD: r = (a != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_strb(input lsu_size_e size, input logic [1:0] a);
    logic [3:0] r;
    case (size)
      SZ_BYTE: r = 4'b0001 << a;
      SZ_HALF: r = 4'b0011 << a;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_lanes(input lsu_size_e size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input lsu_size_e size,
                                               input logic [1:0] a, input logic sgn);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rdata >> {a, 3'b000};
    case (size)
      SZ_BYTE: r = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: r = {{16{sgn & sh[15]}}, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_store_buffer.sv
// Circular store buffer with word-address match against all valid entries.
// LSU_SB_FORWARD_EN adds a youngest-match forward path with byte-coverage check.
module lsu_store_buffer
  import lsu_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  sb_entry_t         push_entry,
  input  logic              pop,
  input  logic [ADDR_W-1:2] match_word,
`ifdef LSU_SB_FORWARD_EN
  input  logic [3:0]        fwd_strb,
  output logic              fwd_ok,
  output logic [31:0]       fwd_data,
`endif
  output sb_entry_t         head,
  output logic              full,
  output logic              empty,
  output logic              hit
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  sb_entry_t        mem_r [SB_DEPTH];
  logic [PTR_W:0]   wr_ptr_r;
  logic [PTR_W:0]   rd_ptr_r;
  logic [PTR_W:0]   count_s;

  // Pointer and storage update; the head entry stays resident until its write completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(PTR_W+1){1'b0}};
      rd_ptr_r <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < SB_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_r[wr_ptr_r[PTR_W-1:0]] <= push_entry;
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  assign full    = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign head    = mem_r[rd_ptr_r[PTR_W-1:0]];
  assign count_s = wr_ptr_r - rd_ptr_r;

`ifdef LSU_SB_FORWARD_EN
  logic [3:0]  yng_strb_s;
  logic [31:0] yng_data_s;
`endif

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             m;
    hit = 1'b0;
    idx = rd_ptr_r[PTR_W-1:0];
    m   = 1'b0;
`ifdef LSU_SB_FORWARD_EN
    yng_strb_s = 4'h0;
    yng_data_s = 32'h0;
`endif
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = rd_ptr_r[PTR_W-1:0] + PTR_W'(i);
      m   = ((PTR_W+1)'(i) < count_s) && (mem_r[idx].addr[ADDR_W-1:2] == match_word);
      hit = hit | m;
`ifdef LSU_SB_FORWARD_EN
      yng_strb_s = m ? mem_r[idx].wstrb : yng_strb_s;
      yng_data_s = m ? mem_r[idx].wdata : yng_data_s;
`endif
    end
  end

`ifdef LSU_SB_FORWARD_EN
  assign fwd_ok   = hit && ((yng_strb_s & fwd_strb) == fwd_strb);
  assign fwd_data = yng_data_s;
`endif

endmodule

// File: rtl/mem_lsu_sb.sv
// MEM-stage load/store unit: posted store buffer, blocking loads, split addr/data bus.
// Define LSU_SB_FORWARD_EN to complete fully covered hazarding loads from the buffer.
module mem_lsu_sb
  import lsu_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_flush,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] bad_addr,
  output logic              sb_empty,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [31:0]       bus_rdata
);

  lsu_state_e        state_r;
  logic              bus_req_r, bus_wr_r, ld_signed_r, discard_r, fwd_pend_r;
  lsu_size_e         bus_size_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [3:0]        bus_wstrb_r;
  logic [31:0]       bus_wdata_r, load_data_r;

  lsu_size_e  size_s;
  logic       misalign_s, ld_req_s, st_req_s, ld_busy_s;
  logic       ld_done_s, ld_ok_s, st_done_s, ld_issue_s, st_issue_s, ld_fwd_s;
  logic       sb_push_s, sb_full_s, sb_empty_s, sb_hit_s;
  logic [31:0] fwd_word_s, bus_load_s;
  sb_entry_t  push_entry_s, head_s;

  assign size_s     = norm_size(req_size);
  assign misalign_s = misaligned(size_s, req_addr[1:0]);
  assign exc_adel   = req_valid & ~req_we & misalign_s;
  assign exc_ades   = req_valid & req_we & misalign_s;
  assign bad_addr   = (exc_adel | exc_ades) ? req_addr : {ADDR_W{1'b0}};
  assign ld_req_s   = req_valid & ~req_we & ~misalign_s & ~req_flush;
  assign st_req_s   = req_valid & req_we & ~misalign_s & ~req_flush;

  assign ld_busy_s  = (state_r == LD_ADDR) | (state_r == LD_DATA);
  assign ld_done_s  = bus_data_ok & ((state_r == LD_DATA) | ((state_r == LD_ADDR) & bus_addr_ok));
  assign st_done_s  = bus_data_ok & ((state_r == ST_DATA) | ((state_r == ST_ADDR) & bus_addr_ok));
  // A flush in the completion cycle also drops the result: it is the load being flushed.
  assign ld_ok_s    = ld_done_s & ~discard_r & ~req_flush;
  assign ld_issue_s = (state_r == IDLE) & ld_req_s & ~fwd_pend_r & ~sb_hit_s & ~ld_fwd_s;
  assign st_issue_s = (state_r == IDLE) & ~ld_issue_s & ~sb_empty_s;
  assign sb_push_s  = st_req_s & (~sb_full_s | st_done_s);

  assign bus_load_s = load_extract(bus_rdata, bus_size_r, bus_addr_r[1:0], ld_signed_r);
  assign load_valid = ld_ok_s | (fwd_pend_r & ~req_flush);
  assign load_data  = ld_ok_s ? bus_load_s : load_data_r;
  assign stall      = (ld_req_s & ~load_valid) | (st_req_s & sb_full_s & ~st_done_s);
  assign sb_empty   = sb_empty_s;

  assign bus_req   = bus_req_r;
  assign bus_wr    = bus_wr_r;
  assign bus_size  = bus_size_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wstrb = bus_wstrb_r;
  assign bus_wdata = bus_wdata_r;

  // Build the lane-aligned buffer entry for an incoming store.
  always_comb begin
    push_entry_s       = '0;
    push_entry_s.addr  = SB_ADDR_MAX'(req_addr);
    push_entry_s.wstrb = lane_strb(size_s, req_addr[1:0]);
    push_entry_s.wdata = store_lanes(size_s, req_wdata);
    push_entry_s.size  = size_s;
  end

`ifdef LSU_SB_FORWARD_EN
  logic        fwd_ok_s;
  logic [31:0] fwd_data_s;
  assign ld_fwd_s   = ld_req_s & ~fwd_pend_r & ~ld_busy_s & sb_hit_s & fwd_ok_s;
  assign fwd_word_s = load_extract(fwd_data_s, size_s, req_addr[1:0], req_signed);
`else
  assign ld_fwd_s   = 1'b0;
  assign fwd_word_s = 32'h0000_0000;
`endif

  lsu_store_buffer #(.SB_DEPTH(SB_DEPTH), .ADDR_W(ADDR_W)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (sb_push_s),
    .push_entry (push_entry_s),
    .pop        (st_done_s),
    .match_word (req_addr[ADDR_W-1:2]),
`ifdef LSU_SB_FORWARD_EN
    .fwd_strb   (lane_strb(size_s, req_addr[1:0])),
    .fwd_ok     (fwd_ok_s),
    .fwd_data   (fwd_data_s),
`endif
    .head       (head_s),
    .full       (sb_full_s),
    .empty      (sb_empty_s),
    .hit        (sb_hit_s)
  );

  if (ADDR_W < SB_ADDR_MAX) begin : g_addr_tap
    logic head_addr_unused;
    assign head_addr_unused = ^head_s.addr[SB_ADDR_MAX-1:ADDR_W];
  end

  // Bus FSM with registered request signals, discard tracking and load result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      bus_req_r   <= 1'b0;
      bus_wr_r    <= 1'b0;
      bus_size_r  <= SZ_BYTE;
      bus_addr_r  <= {ADDR_W{1'b0}};
      bus_wstrb_r <= 4'h0;
      bus_wdata_r <= 32'h0000_0000;
      ld_signed_r <= 1'b0;
      discard_r   <= 1'b0;
      fwd_pend_r  <= 1'b0;
      load_data_r <= 32'h0000_0000;
    end else begin
      fwd_pend_r <= ld_fwd_s;
      if (ld_ok_s) begin
        load_data_r <= bus_load_s;
      end else if (ld_fwd_s) begin
        load_data_r <= fwd_word_s;
      end
      if (ld_done_s) begin
        discard_r <= 1'b0;
      end else if (req_flush & ld_busy_s) begin
        discard_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (ld_issue_s) begin
            state_r     <= LD_ADDR;
            bus_req_r   <= 1'b1;
            bus_wr_r    <= 1'b0;
            bus_size_r  <= size_s;
            bus_addr_r  <= req_addr;
            bus_wstrb_r <= 4'h0;
            bus_wdata_r <= 32'h0000_0000;
            ld_signed_r <= req_signed;
          end else if (st_issue_s) begin
            state_r     <= ST_ADDR;
            bus_req_r   <= 1'b1;
            bus_wr_r    <= 1'b1;
            bus_size_r  <= head_s.size;
            bus_addr_r  <= head_s.addr[ADDR_W-1:0];
            bus_wstrb_r <= head_s.wstrb;
            bus_wdata_r <= head_s.wdata;
          end else begin
            state_r <= IDLE;
          end
        end
        LD_ADDR: begin
          if (bus_addr_ok) begin
            bus_req_r <= 1'b0;
            state_r   <= bus_data_ok ? IDLE : LD_DATA;
          end else begin
            state_r <= LD_ADDR;
          end
        end
        LD_DATA: state_r <= bus_data_ok ? IDLE : LD_DATA;
        ST_ADDR: begin
          if (bus_addr_ok) begin
            bus_req_r <= 1'b0;
            state_r   <= bus_data_ok ? IDLE : ST_DATA;
          end else begin
            state_r <= ST_ADDR;
          end
        end
        ST_DATA: state_r <= bus_data_ok ? IDLE : ST_DATA;
        default: begin
          state_r   <= IDLE;
          bus_req_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
